debug_unit: RTL and testbench

- UART-side control block sitting directly upstream of the MIPS pipeline inside top_modular; consumes command/program bytes from the UART receiver.
- Loads the instruction memory, then runs the processor in continuous or step-by-step mode.
- Reports cycle count and PC back through the UART transmitter.
- Command bytes:
  - Start = 0x01
  - Continuous = 0x02
  - StepByStep = 0x03
  - ReProgram = 0x05
  - Step = 0x06

---
 rtl/debug_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_debug_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// UART-side debug controller: loads instruction memory from received bytes, runs the
// pipeline continuously or one step at a time, and reports cycle count and PC back.
module debug_unit #(
   parameter int             LEN       = 32,
   parameter int             ADDR_W    = 10,
   parameter logic [LEN-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   input  logic              tx_done,
   input  logic              halt,
   input  logic [LEN-1:0]    pc,
   output logic              cpu_enable,
   output logic              cpu_reset,
   output logic              imem_wr_en,
   output logic [ADDR_W-1:0] imem_wr_addr,
   output logic [LEN-1:0]    imem_wr_data,
   output logic              tx_start,
   output logic [7:0]        tx_data
);

   localparam int WORD_BYTES = LEN / 8;
   localparam int REP_BYTES  = (2 * LEN) / 8;
   localparam int BCW        = $clog2(WORD_BYTES);
   localparam int TIW        = $clog2(REP_BYTES);

   localparam logic [7:0] CMD_START   = 8'h01;
   localparam logic [7:0] CMD_CONT    = 8'h02;
   localparam logic [7:0] CMD_STEPMOD = 8'h03;
   localparam logic [7:0] CMD_REPROG  = 8'h05;
   localparam logic [7:0] CMD_STEP    = 8'h06;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PROG     = 3'd1,
      S_WAIT     = 3'd2,
      S_CONT     = 3'd3,
      S_STEP     = 3'd4,
      S_STEP_RUN = 3'd5,
      S_SEND     = 3'd6
   } state_e;

   state_e              state_q, state_d;
   logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN-1:0]      word_q, word_d;
   logic [LEN-1:0]      cycle_count_q, cycle_count_d;
   logic [2*LEN-1:0]    report_q, report_d;
   logic [TIW-1:0]      tx_idx_q, tx_idx_d;
   logic                tx_wait_q, tx_wait_d;
   logic                from_step_q, from_step_d;
   logic                cpu_enable_q, cpu_enable_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                imem_wr_en_q, imem_wr_en_d;
   logic [ADDR_W-1:0]   imem_wr_addr_q, imem_wr_addr_d;
   logic [LEN-1:0]      imem_wr_data_q, imem_wr_data_d;
   logic                tx_start_q, tx_start_d;
   logic [7:0]          tx_data_q, tx_data_d;

   logic [LEN-1:0]      assembled_s;
   logic                enter_prog_s;

   assign assembled_s = {word_q[LEN-9:0], rx_data};

   // Next-state and registered-output logic for the whole controller.
   always_comb begin
      state_d        = state_q;
      byte_cnt_d     = byte_cnt_q;
      addr_d         = addr_q;
      word_d         = word_q;
      cycle_count_d  = cycle_count_q;
      report_d       = report_q;
      tx_idx_d       = tx_idx_q;
      tx_wait_d      = tx_wait_q;
      from_step_d    = from_step_q;
      cpu_enable_d   = 1'b0;
      cpu_reset_d    = 1'b0;
      imem_wr_en_d   = 1'b0;
      imem_wr_addr_d = imem_wr_addr_q;
      imem_wr_data_d = imem_wr_data_q;
      tx_start_d     = 1'b0;
      tx_data_d      = tx_data_q;
      enter_prog_s   = 1'b0;

      if (cpu_enable_q) begin
         cycle_count_d = cycle_count_q + LEN'(1'b1);
      end else begin
         cycle_count_d = cycle_count_q;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_done && (rx_data == CMD_START)) begin
               enter_prog_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PROG: begin
            if (rx_done) begin
               word_d = assembled_s;
               if (byte_cnt_q == BCW'(WORD_BYTES - 1)) begin
                  byte_cnt_d     = '0;
                  imem_wr_en_d   = 1'b1;
                  imem_wr_addr_d = addr_q;
                  imem_wr_data_d = assembled_s;
                  addr_d         = addr_q + ADDR_W'(1'b1);
                  if (assembled_s == HALT_WORD) begin
                     state_d = S_WAIT;
                  end else begin
                     state_d = S_PROG;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + BCW'(1'b1);
               end
            end else begin
               state_d = S_PROG;
            end
         end
         S_WAIT: begin
            if (rx_done) begin
               case (rx_data)
                  CMD_CONT: begin
                     state_d      = S_CONT;
                     cpu_enable_d = 1'b1;
                  end
                  CMD_STEPMOD: state_d = S_STEP;
                  CMD_REPROG:  enter_prog_s = 1'b1;
                  default:     state_d = S_WAIT;
               endcase
            end else begin
               state_d = S_WAIT;
            end
         end
         // The halt cycle itself is still an enabled cycle, so the report includes it.
         S_CONT: begin
            if (halt) begin
               state_d     = S_SEND;
               report_d    = {cycle_count_q + LEN'(1'b1), pc};
               from_step_d = 1'b0;
               tx_idx_d    = '0;
               tx_wait_d   = 1'b0;
            end else begin
               cpu_enable_d = 1'b1;
            end
         end
         S_STEP: begin
            if (rx_done) begin
               case (rx_data)
                  CMD_STEP: begin
                     state_d      = S_STEP_RUN;
                     cpu_enable_d = 1'b1;
                  end
                  CMD_REPROG: enter_prog_s = 1'b1;
                  default:    state_d = S_STEP;
               endcase
            end else begin
               state_d = S_STEP;
            end
         end
         S_STEP_RUN: begin
            state_d     = S_SEND;
            report_d    = {cycle_count_q + LEN'(1'b1), pc};
            from_step_d = 1'b1;
            tx_idx_d    = '0;
            tx_wait_d   = 1'b0;
         end
         S_SEND: begin
            if (!tx_wait_q) begin
               tx_start_d = 1'b1;
               tx_data_d  = report_q[2*LEN-1 -: 8];
               report_d   = {report_q[2*LEN-9:0], 8'h00};
               tx_wait_d  = 1'b1;
            end else if (tx_done) begin
               tx_wait_d = 1'b0;
               if (tx_idx_q == TIW'(REP_BYTES - 1)) begin
                  tx_idx_d = '0;
                  if (from_step_q && !halt) begin
                     state_d = S_STEP;
                  end else begin
                     state_d = S_WAIT;
                  end
               end else begin
                  tx_idx_d = tx_idx_q + TIW'(1'b1);
               end
            end else begin
               tx_wait_d = tx_wait_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (enter_prog_s) begin
         state_d       = S_PROG;
         cpu_reset_d   = 1'b1;
         byte_cnt_d    = '0;
         addr_d        = '0;
         cycle_count_d = '0;
      end else begin
         cpu_reset_d = 1'b0;
      end
   end

   // State and output registers; reset aborts any load, run or report in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         byte_cnt_q     <= '0;
         addr_q         <= '0;
         word_q         <= '0;
         cycle_count_q  <= '0;
         report_q       <= '0;
         tx_idx_q       <= '0;
         tx_wait_q      <= 1'b0;
         from_step_q    <= 1'b0;
         cpu_enable_q   <= 1'b0;
         cpu_reset_q    <= 1'b0;
         imem_wr_en_q   <= 1'b0;
         imem_wr_addr_q <= '0;
         imem_wr_data_q <= '0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= 8'h00;
      end else begin
         state_q        <= state_d;
         byte_cnt_q     <= byte_cnt_d;
         addr_q         <= addr_d;
         word_q         <= word_d;
         cycle_count_q  <= cycle_count_d;
         report_q       <= report_d;
         tx_idx_q       <= tx_idx_d;
         tx_wait_q      <= tx_wait_d;
         from_step_q    <= from_step_d;
         cpu_enable_q   <= cpu_enable_d;
         cpu_reset_q    <= cpu_reset_d;
         imem_wr_en_q   <= imem_wr_en_d;
         imem_wr_addr_q <= imem_wr_addr_d;
         imem_wr_data_q <= imem_wr_data_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
      end
   end

   assign cpu_enable   = cpu_enable_q;
   assign cpu_reset    = cpu_reset_q;
   assign imem_wr_en   = imem_wr_en_q;
   assign imem_wr_addr = imem_wr_addr_q;
   assign imem_wr_data = imem_wr_data_q;
   assign tx_start     = tx_start_q;
   assign tx_data      = tx_data_q;

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: randomized UART byte stimulus, a small pipeline/transmitter
// model, and expected memory writes and report bytes derived from the command rules.
module tb_debug_unit;
   localparam int LEN    = 32;
   localparam int ADDR_W = 10;
   localparam logic [LEN-1:0] HALT = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_done = 1'b0;
   logic              tx_done = 1'b0;
   logic              halt = 1'b0;
   logic [LEN-1:0]    pc = '0;
   logic              cpu_enable, cpu_reset, imem_wr_en, tx_start;
   logic [ADDR_W-1:0] imem_wr_addr;
   logic [LEN-1:0]    imem_wr_data;
   logic [7:0]        tx_data;

   debug_unit #(.LEN(LEN), .ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
      .halt(halt), .pc(pc), .cpu_enable(cpu_enable), .cpu_reset(cpu_reset),
      .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
      .tx_start(tx_start), .tx_data(tx_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [LEN-1:0]    d;
   } wr_t;

   wr_t         exp_wr[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] prog[$];
   int n_vec = 0, n_err = 0;
   int en_total = 0, rst_total = 0, tx_seen = 0;
   int exp_rst = 0, wr_idx = 0;
   logic [31:0] exp_cc = '0, exp_pc = '0;
   bit tx_busy = 1'b0;
   int tx_cd = 0;
   int run_target = 0, en_run = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a write or a tx byte.
   always @(negedge clk) begin
      wr_t e;
      if (reset) begin
         if (cpu_enable) en_total++;
         if (cpu_reset) rst_total++;
         if (imem_wr_en) begin
            if (exp_wr.size() == 0) check("unexpected_write", 64'd1, 64'd0);
            else begin
               e = exp_wr.pop_front();
               check("wr_addr", 64'(imem_wr_addr), 64'(e.a));
               check("wr_data", 64'(imem_wr_data), 64'(e.d));
            end
         end
         if (tx_start) begin
            tx_seen++;
            if (exp_tx.size() == 0) check("unexpected_tx", 64'd1, 64'd0);
            else check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
         end
      end
   end

   // Pipeline model: PC advances by 4 per enabled cycle, halt raised after run_target cycles.
   always @(negedge clk) begin
      if (reset) begin
         if (cpu_reset) pc = '0;
         if (cpu_enable) begin
            pc = pc + 32'd4;
            en_run++;
            if (run_target > 0 && en_run >= run_target) halt = 1'b1;
         end
      end
   end

   // Transmitter model: random latency, and tx_start while still busy is a protocol error.
   always @(negedge clk) begin
      if (!reset) begin
         tx_busy = 1'b0;
         tx_done = 1'b0;
      end else begin
         if (tx_start) check("tx_start_gap", 64'(tx_busy), 64'd0);
         if (tx_done) begin
            tx_done = 1'b0;
            tx_busy = 1'b0;
         end else if (tx_busy) begin
            if (tx_cd == 0) tx_done = 1'b1;
            else tx_cd--;
         end
         if (tx_start) begin
            tx_busy = 1'b1;
            tx_cd   = $urandom_range(0, 3);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 4000; i++) begin
         if (exp_wr.size() == 0 && exp_tx.size() == 0 && !tx_busy) break;
         @(posedge clk);
      end
      if (exp_wr.size() != 0 || exp_tx.size() != 0 || tx_busy) check("drain_timeout", 64'd1, 64'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic load_prog();
      logic [31:0] w;
      while (prog.size() != 0) begin
         w = prog.pop_front();
         exp_wr.push_back('{a: wr_idx[ADDR_W-1:0], d: w});
         wr_idx++;
         for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
      end
      drain();
   endtask

   task automatic enter_prog(input logic [7:0] cmd);
      exp_rst++;
      exp_cc = '0;
      exp_pc = '0;
      wr_idx = 0;
      send_byte(cmd);
   endtask

   task automatic push_report();
      for (int i = 3; i >= 0; i--) exp_tx.push_back(exp_cc[8*i +: 8]);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(exp_pc[8*i +: 8]);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h1234_5678;
      return w;
   endfunction

   task automatic run_cont(input int n);
      int e0;
      e0 = en_total;
      en_run = 0;
      run_target = n;
      exp_cc = exp_cc + 32'(n);
      exp_pc = exp_pc + 32'(4 * n);
      push_report();
      send_byte(8'h02);
      drain();
      check("cont_en_cycles", 64'(en_total - e0), 64'(n));
      run_target = 0;
      halt = 1'b0;
   endtask

   task automatic run_step();
      int e0;
      e0 = en_total;
      exp_cc = exp_cc + 32'd1;
      exp_pc = exp_pc + 32'd4;
      push_report();
      send_byte(8'h06);
      drain();
      check("step_en_cycles", 64'(en_total - e0), 64'd1);
   endtask

   task automatic junk(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
      logic [7:0] b;
      int e0;
      e0 = en_total;
      for (int i = 0; i < 4; i++) begin
         do b = 8'($urandom); while (b == x0 || b == x1 || b == x2);
         send_byte(b);
      end
      repeat (4) @(negedge clk);
      check("junk_ignored", 64'(en_total - e0), 64'd0);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({cpu_enable, cpu_reset, imem_wr_en, imem_wr_addr, imem_wr_data, tx_start, tx_data});
   endfunction

   initial begin
      int t0, e0;
      #1 check("reset_outputs", all_outs(), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_outputs", all_outs(), 64'd0);
      junk(8'h01, 8'h01, 8'h01);
      send_byte(8'h02);
      send_byte(8'h06);

      // Basic load, continuous run of 5 cycles at pc 0x14.
      enter_prog(8'h01);
      prog.push_back(32'h0000_002A);
      prog.push_back(HALT);
      load_prog();
      check("cpu_reset_pulses", 64'(rst_total), 64'(exp_rst));
      junk(8'h02, 8'h03, 8'h05);
      run_cont(5);

      // Reprogram from WAIT_MODE, then three steps, then reprogram from STEP_BY_STEP.
      enter_prog(8'h05);
      prog.push_back(rand_word());
      prog.push_back(HALT);
      load_prog();
      check("cpu_reset_pulses", 64'(rst_total), 64'(exp_rst));
      send_byte(8'h03);
      for (int i = 0; i < 3; i++) begin
         run_step();
         junk(8'h05, 8'h06, 8'h06);
      end
      enter_prog(8'h05);
      prog.push_back(rand_word());
      prog.push_back(rand_word());
      prog.push_back(HALT);
      load_prog();
      check("cpu_reset_pulses", 64'(rst_total), 64'(exp_rst));
      run_cont($urandom_range(3, 20));

      // Halt already high on entry: one enabled cycle.
      halt = 1'b1;
      run_cont(1);

      // Step with halt high returns to WAIT_MODE: a further step command is ignored.
      send_byte(8'h03);
      halt = 1'b1;
      run_step();
      e0 = en_total;
      send_byte(8'h06);
      repeat (6) @(negedge clk);
      check("step_after_halt_ignored", 64'(en_total - e0), 64'd0);
      check("no_report_after_halt", 64'(tx_busy), 64'd0);
      halt = 1'b0;

      // Reset during the 4th report byte.
      t0 = tx_seen;
      en_run = 0;
      run_target = 3;
      exp_cc = exp_cc + 32'd3;
      exp_pc = exp_pc + 32'd12;
      push_report();
      send_byte(8'h02);
      for (int i = 0; i < 2000 && (tx_seen - t0) < 4; i++) @(posedge clk);
      check("reached_4th_byte", 64'(tx_seen - t0), 64'd4);
      #3 reset = 1'b0;
      #1 check("async_reset_outputs", all_outs(), 64'd0);
      exp_tx.delete();
      halt = 1'b0;
      run_target = 0;
      pc = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      e0 = en_total;
      t0 = rst_total;
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h06);
      send_byte(8'h05);
      repeat (5) @(negedge clk);
      check("cmds_ignored_after_reset", 64'(en_total - e0), 64'd0);
      check("no_cpu_reset_after_reset", 64'(rst_total - t0), 64'd0);
      check("no_tx_after_reset", 64'(tx_busy), 64'd0);

      // Reload, then a program longer than memory: addresses wrap and overwrite.
      rst_total = exp_rst;
      enter_prog(8'h01);
      prog.push_back(rand_word());
      prog.push_back(HALT);
      load_prog();
      enter_prog(8'h05);
      for (int i = 0; i < (1 << ADDR_W) + 1; i++) prog.push_back(rand_word());
      prog.push_back(HALT);
      load_prog();
      check("cpu_reset_pulses", 64'(rst_total), 64'(exp_rst));
      run_cont(2);
      send_byte(8'h03);
      run_step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1);
   end
endmodule
